// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-write controller.
//   state_t   : controller FSM states
//   NUM_BYTES : depth of the downstream memory in bytes
//   ADDR_W    : width of the byte address
package mem_ctrl_pkg;

  localparam int NUM_BYTES = 4;
  localparam int ADDR_W    = $clog2(NUM_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Conditions one raw pushbutton: 2-flop synchronizer, counting debouncer,
// and a rising-edge detector on the debounced level.
//   clk, reset : system clock, synchronous active-high reset
//   i_btn      : raw asynchronous, bouncy button
//   o_level    : debounced level (flop output)
//   o_press    : one-cycle pulse on a debounced 0->1 change
module btn_debounce #(
  parameter int DB_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  // +1 so the width stays non-zero for DB_CYCLES = 1
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Count consecutive cycles of disagreement; any agreement restarts
      // the count, so a bounce shorter than DB_CYCLES never flips the level.
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  // Both terms are flops, so the pulse is glitch-free and lasts one cycle.
  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/mem_write_ctrl.sv
// Writes a switch byte into a 4-byte downstream memory on a debounced
// store button press; a second button (or auto-increment) steps the address.
//   clk, reset : system clock, synchronous active-high reset
//   sw_data    : byte captured on the store press
//   btn_store  : raw store button
//   btn_next   : raw address-advance button
//   auto_inc   : advance address after each write
//   data/store/addr/busy : registered memory write port and status
module mem_write_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 100000,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              btn_store,
  input  logic              btn_next,
  input  logic              auto_inc,
  output logic [DATA_W-1:0] data,
  output logic              store,
  output logic [ADDR_W-1:0] addr,
  output logic              busy
);

  logic w_store_level;
  logic w_store_press;
  logic w_next_unused;
  logic w_next_press;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_store (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_store),
    .o_level (w_store_level),
    .o_press (w_store_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn_next),
    .o_level (w_next_unused),
    .o_press (w_next_press)
  );

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_data;
  logic              r_store;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_store_press) w_next_state = WRITE;
      WRITE:   w_next_state = HOLD;
      // Wait out the debounced release so one press yields one write.
      HOLD:    if (!w_store_level) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_store <= 1'b0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Strobe and busy are registered from the next state so they line up
      // with the state flop without any input-to-output path.
      r_store <= (w_next_state == WRITE);
      r_busy  <= (w_next_state != IDLE);
      if (r_state == IDLE && w_store_press) r_data <= sw_data;
      // Store wins over next when both fire in IDLE; next is dropped.
      if (r_state == WRITE && auto_inc)
        r_addr <= r_addr + 1'b1;
      else if (r_state == IDLE && !w_store_press && w_next_press)
        r_addr <= r_addr + 1'b1;
    end
  end

  assign data  = r_data;
  assign store = r_store;
  assign addr  = r_addr;
  assign busy  = r_busy;

endmodule
